// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode encodings and sizing helper for the LED pattern engine
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;

  // Bits needed to hold the values 0..limit-1 (at least one bit).
  function automatic int regsize(input int limit);
    int r;
    r = 1;
    while ((64'd1 << r) < 64'(limit)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the board clock down to one step pulse every TickDiv enabled cycles
module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int TickDiv = 12000000
) (
  input  logic clk,
  input  logic rstx,
  input  logic en,
  output logic wrap,
  output logic tick
);

  localparam int CntW = regsize(TickDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt;

  // wrap marks the edge on which the pattern steps; tick is its registered twin
  assign wrap = en && (cnt == CntMax);

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) cnt <= '0;
      else if (en) cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - four-mode LED pattern engine with global PWM brightness and selectable polarity
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int TickDiv   = 12000000,
  parameter int NumLeds   = 8,
  parameter int PwmBits   = 4,
  parameter bit ActiveLow = 1'b1
) (
  input  logic               clk,
  input  logic               rstx,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [PwmBits-1:0] brightness,
  output logic               tick,
  output logic [NumLeds-1:0] pattern,
  output logic [NumLeds-1:0] ledx
);

  if (NumLeds < 2 || TickDiv < 2) begin : g_bad_param
    $error("led_pattern_gen: NumLeds and TickDiv must both be >= 2");
  end

  localparam logic [NumLeds-1:0] LsbOnly  = NumLeds'(1);
  localparam logic [NumLeds-1:0] Inactive = {NumLeds{ActiveLow}};

  logic               step;
  mode_e              mode_q, mode_q_n;
  logic               dir_down, dir_down_n;
  logic [NumLeds-1:0] pattern_n, ledx_n;
  logic [PwmBits-1:0] pwm_cnt;
  logic               onehot, pwm_on;

  tick_prescaler #(.TickDiv(TickDiv)) u_prescaler (
    .clk  (clk),
    .rstx (rstx),
    .en   (en),
    .wrap (step),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      mode_q   <= MODE_COUNT;
      dir_down <= 1'b0;
      pattern  <= '0;
      pwm_cnt  <= '0;
      ledx     <= Inactive;
    end else begin
      mode_q   <= mode_q_n;
      dir_down <= dir_down_n;
      pattern  <= pattern_n;
      pwm_cnt  <= pwm_cnt + PwmBits'(1);
      ledx     <= ledx_n;
    end
  end

  assign onehot = (pattern != '0) && ((pattern & (pattern - LsbOnly)) == '0);

  always_comb begin
    mode_q_n   = mode_q;
    dir_down_n = dir_down;
    pattern_n  = pattern;
    if (step) begin
      if (mode_e'(mode) != mode_q) begin
        // a new mode always restarts from its own start value
        mode_q_n   = mode_e'(mode);
        dir_down_n = 1'b0;
        case (mode_e'(mode))
          MODE_COUNT: pattern_n = '0;
          MODE_BLINK: pattern_n = '1;
          default:    pattern_n = LsbOnly;
        endcase
      end else begin
        case (mode_q)
          MODE_COUNT: pattern_n = pattern + LsbOnly;
          MODE_BLINK: pattern_n = ~pattern;
          MODE_BOUNCE: begin
            if (!onehot) begin
              pattern_n  = LsbOnly;
              dir_down_n = 1'b0;
            end else if (!dir_down) begin
              pattern_n = pattern << 1;
              if (pattern[NumLeds-2]) dir_down_n = 1'b1;
            end else begin
              pattern_n = pattern >> 1;
              if (pattern[1]) dir_down_n = 1'b0;
            end
          end
          default: pattern_n = onehot ? {pattern[NumLeds-2:0], pattern[NumLeds-1]} : LsbOnly;
        endcase
      end
    end
  end

  always_comb begin
    pwm_on = (&brightness) || (pwm_cnt < brightness);
    ledx_n = (pattern & {NumLeds{pwm_on}}) ^ Inactive;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized and directed checks of led_pattern_gen against a behavioural model
module tb_led_pattern_gen;

  localparam int TD = 4;
  localparam int NL = 4;
  localparam int PB = 2;

  logic          clk = 1'b0;
  logic          rstx = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PB-1:0] brightness = 2'd3;
  logic          tick;
  logic [NL-1:0] pattern;
  logic [NL-1:0] ledx;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  led_pattern_gen #(.TickDiv(TD), .NumLeds(NL), .PwmBits(PB), .ActiveLow(1'b1)) dut (
    .clk        (clk),
    .rstx       (rstx),
    .en         (en),
    .mode       (mode),
    .brightness (brightness),
    .tick       (tick),
    .pattern    (pattern),
    .ledx       (ledx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: step counter, bounce phase as a position in the 2N-2 long sweep
  int m_presc, m_tick, m_pat, m_modeq, m_phase, m_pwm, m_ledx;

  function automatic int bounce_bit(input int ph);
    return (ph < NL) ? ph : (2 * NL - 2 - ph);
  endfunction

  always @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      m_presc = 0; m_tick = 0; m_pat = 0; m_modeq = 0; m_phase = 0; m_pwm = 0;
      m_ledx = (1 << NL) - 1;
    end else begin
      m_ledx = ((1 << NL) - 1) & ~(((brightness == 3) || (m_pwm < brightness)) ? m_pat : 0);
      m_pwm  = (m_pwm + 1) % (1 << PB);
      m_tick = 0;
      if (en) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          m_tick  = 1;
          if (int'(mode) != m_modeq) begin
            m_modeq = mode;
            m_phase = 0;
            m_pat   = (mode == 0) ? 0 : (mode == 1) ? (1 << NL) - 1 : 1;
          end else begin
            case (m_modeq)
              0: m_pat = (m_pat + 1) % (1 << NL);
              1: m_pat = ((1 << NL) - 1) - m_pat;
              2: begin
                m_phase = (m_phase + 1) % (2 * NL - 2);
                m_pat   = 1 << bounce_bit(m_phase);
              end
              default: begin
                m_pat = ((m_pat << 1) | (m_pat >> (NL - 1))) & ((1 << NL) - 1);
                if ($countones(m_pat) != 1) m_pat = 1;
              end
            endcase
          end
        end else begin
          m_presc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_tick", int'(tick), m_tick);
      chk("model_pattern", int'(pattern), m_pat);
      chk("model_ledx", int'(ledx), m_ledx);
    end
  end

  task automatic wait_tick(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 * TD && !got; i++) begin
      @(negedge clk);
      if (tick) got = 1'b1;
    end
    if (!got) begin
      bad++;
      total++;
      $display("FAIL %s actual=no_tick required=tick_within_%0d", name, 4 * TD);
    end
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) brightness = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int zeros, ones, held;
    int bseq[8] = '{1, 2, 4, 8, 4, 2, 1, 2};

    // 1. reset, then binary count
    repeat (3) @(negedge clk);
    chk("reset_ledx", int'(ledx), 15);
    chk("reset_tick", int'(tick), 0);
    chk("reset_pattern", int'(pattern), 0);
    started = 1'b1;
    #1;
    en = 1'b1; mode = 2'd0; brightness = 2'd3; rstx = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wait_tick("count_tick");
      chk("count_pattern", int'(pattern), i % 16);
      @(negedge clk);
      chk("count_ledx_lag", int'(ledx), 15 - (i % 16));
    end

    // 2. blink, switched mid-period
    @(negedge clk); #1;
    mode = 2'd1;
    chk("blink_no_early_change", int'(pattern), 0);
    wait_tick("blink_tick0");
    chk("blink_p0", int'(pattern), 15);
    @(negedge clk);
    chk("blink_l0", int'(ledx), 0);
    wait_tick("blink_tick1");
    chk("blink_p1", int'(pattern), 0);
    @(negedge clk);
    chk("blink_l1", int'(ledx), 15);
    wait_tick("blink_tick2");
    chk("blink_p2", int'(pattern), 15);

    // 3. bounce sweep
    #1; mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      wait_tick("bounce_tick");
      chk("bounce_pattern", int'(pattern), bseq[i]);
    end

    // 4. freeze with prescaler at 2
    wait_tick("freeze_sync");
    @(negedge clk);
    @(negedge clk); #1;
    en = 1'b0;
    held = pattern;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("freeze_tick", int'(tick), 0);
      chk("freeze_pattern", int'(pattern), held);
    end
    #1; en = 1'b1;
    @(negedge clk);
    chk("unfreeze_edge1_tick", int'(tick), 0);
    @(negedge clk);
    chk("unfreeze_edge2_tick", int'(tick), 1);

    // 5. PWM on a frozen all-ones blink pattern
    #1; mode = 2'd1;
    for (int i = 0; i < 3 && pattern != 4'hF; i++) wait_tick("pwm_sync");
    chk("pwm_pattern_all_on", int'(pattern), 15);
    #1; en = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1; brightness = 2'(b);
      repeat (2) @(negedge clk);
      zeros = 0; ones = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (ledx == 4'h0) zeros++;
        else if (ledx == 4'hF) ones++;
      end
      chk("pwm_active_cycles", zeros, (b == 3) ? 8 : 2 * b);
      chk("pwm_inactive_cycles", ones, (b == 3) ? 0 : 8 - 2 * b);
    end

    // randomized mix of modes, enables and brightness
    run_random(600);

    // 6. async reset in rotate mode
    #1; en = 1'b1; mode = 2'd3; brightness = 2'd3;
    for (int i = 0; i < 8 && pattern != 4'h4; i++) wait_tick("rotate_sync");
    chk("rotate_at_0100", int'(pattern), 4);
    #2; rstx = 1'b0;
    #1;
    chk("async_ledx", int'(ledx), 15);
    chk("async_tick", int'(tick), 0);
    chk("async_pattern", int'(pattern), 0);
    @(negedge clk); #1;
    rstx = 1'b1;
    wait_tick("rotate_after_reset");
    chk("rotate_first", int'(pattern), 1);
    wait_tick("rotate_second");
    chk("rotate_second_p", int'(pattern), 2);

    run_random(400);
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
